// File: rtl/dq_capture_if.sv
// Read-capture bus between the test controller and dq_capture.
// The DQ_CAPTURE_CMP_EN macro adds the expected-data comparison outputs.
interface dq_capture_if #(
  parameter int DEPTH = 8,
  parameter int LAT_W = 5
);
  logic                     RD;
  logic [LAT_W-1:0]         RD_LAT;
  logic [7:0]               DQ_OUT;
  logic [7:0]               DQ_EXP;
  logic                     OUT_READY;
  logic                     OUT_VALID;
  logic [7:0]               OUT_DATA;
  logic [$clog2(DEPTH):0]   FIFO_LEVEL;
  logic                     OVERFLOW;
  logic                     COLLIDE;
`ifdef DQ_CAPTURE_CMP_EN
  logic                     MISMATCH;
  logic [15:0]              MISMATCH_CNT;

  modport master (
    output RD, RD_LAT, DQ_OUT, DQ_EXP, OUT_READY,
    input  OUT_VALID, OUT_DATA, FIFO_LEVEL, OVERFLOW, COLLIDE, MISMATCH, MISMATCH_CNT
  );
  modport slave (
    input  RD, RD_LAT, DQ_OUT, DQ_EXP, OUT_READY,
    output OUT_VALID, OUT_DATA, FIFO_LEVEL, OVERFLOW, COLLIDE, MISMATCH, MISMATCH_CNT
  );
`else
  modport master (
    output RD, RD_LAT, DQ_OUT, DQ_EXP, OUT_READY,
    input  OUT_VALID, OUT_DATA, FIFO_LEVEL, OVERFLOW, COLLIDE
  );
  modport slave (
    input  RD, RD_LAT, DQ_OUT, DQ_EXP, OUT_READY,
    output OUT_VALID, OUT_DATA, FIFO_LEVEL, OVERFLOW, COLLIDE
  );
`endif
endinterface

// File: rtl/dq_capture.sv
// Samples DQ_OUT a programmable number of cycles after each RD and queues the bytes.
// Optional DQ_CAPTURE_CMP_EN compares each captured byte against DQ_EXP given with RD.
module dq_capture #(
  parameter int DEPTH = 8,
  parameter int LAT_W = 5
) (
  input logic         CLK,
  input logic         RST_N,
  dq_capture_if.slave bus
);
  localparam int NSLOT = 1 << LAT_W;
  localparam int AW    = $clog2(DEPTH);
  localparam int LW    = AW + 1;

  logic [NSLOT-1:0] pend_q, pend_d;
  logic [LAT_W-1:0] lat_m1;
  logic             lat_zero, capture, collide;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [LW-1:0] level_q;
  logic          full, pop, push;
  logic          overflow_q, collide_q;

  // Pending schedule: shift first, then drop the new RD into slot L-1
  always_comb begin
    lat_zero = (bus.RD_LAT == '0);
    lat_m1   = bus.RD_LAT - LAT_W'(1);
    pend_d   = pend_q >> 1;
    collide  = 1'b0;
    if (bus.RD) begin
      if (lat_zero) begin
        collide = pend_q[0];
      end else begin
        collide        = pend_d[lat_m1];
        pend_d[lat_m1] = 1'b1;
      end
    end
    capture = pend_q[0] | (bus.RD & lat_zero);
  end

  assign full = (level_q == LW'(DEPTH));
  assign pop  = (level_q != '0) && bus.OUT_READY;
  assign push = capture && (!full || pop);

  always_ff @(posedge CLK) begin
    if (push) mem_q[wr_ptr_q] <= bus.DQ_OUT;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pend_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
      collide_q  <= 1'b0;
    end else begin
      pend_q <= pend_d;
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
      overflow_q <= overflow_q | (capture & full & ~pop);
      collide_q  <= collide_q | collide;
    end
  end

  assign bus.OUT_VALID  = (level_q != '0);
  assign bus.OUT_DATA   = bus.OUT_VALID ? mem_q[rd_ptr_q] : 8'h00;
  assign bus.FIFO_LEVEL = level_q;
  assign bus.OVERFLOW   = overflow_q;
  assign bus.COLLIDE    = collide_q;

`ifdef DQ_CAPTURE_CMP_EN
  logic [7:0]  exp_q [NSLOT];
  logic [7:0]  exp_d [NSLOT];
  logic [7:0]  exp_now;
  logic        miss;
  logic        mismatch_q;
  logic [15:0] miss_cnt_q;

  // Expected bytes ride alongside pend; a colliding RD leaves the older byte in place
  always_comb begin
    for (int i = 0; i < NSLOT - 1; i++) exp_d[i] = exp_q[i+1];
    exp_d[NSLOT-1] = 8'h00;
    if (bus.RD && !lat_zero && !collide) exp_d[lat_m1] = bus.DQ_EXP;
    exp_now = pend_q[0] ? exp_q[0] : bus.DQ_EXP;
    miss    = capture && (bus.DQ_OUT != exp_now);
  end

  always_ff @(posedge CLK) begin
    exp_q <= exp_d;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      mismatch_q <= 1'b0;
      miss_cnt_q <= '0;
    end else if (miss) begin
      mismatch_q <= 1'b1;
      if (miss_cnt_q != 16'hFFFF) miss_cnt_q <= miss_cnt_q + 16'd1;
    end
  end

  assign bus.MISMATCH     = mismatch_q;
  assign bus.MISMATCH_CNT = miss_cnt_q;
`else
  logic unused_exp;
  assign unused_exp = ^bus.DQ_EXP;
`endif
endmodule

// File: tb/tb_dq_capture.sv
// Directed bench for dq_capture: latency, L=0 capture, collision, full FIFO and mid-run reset.
module tb_dq_capture;
  localparam int DEPTH = 8;
  localparam int LAT_W = 5;

  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  int   total = 0;
  int   fails = 0;

  always #5 CLK = ~CLK;

  dq_capture_if #(.DEPTH(DEPTH), .LAT_W(LAT_W)) bus ();

  dq_capture #(.DEPTH(DEPTH), .LAT_W(LAT_W)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus.slave)
  );

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic [LAT_W-1:0] lat, input logic [7:0] exp);
    bus.RD     = 1'b1;
    bus.RD_LAT = lat;
    bus.DQ_EXP = exp;
  endtask

  initial begin
    bus.RD = 1'b0; bus.RD_LAT = '0; bus.DQ_OUT = 8'h00; bus.DQ_EXP = 8'h00; bus.OUT_READY = 1'b0;
    step(); step();
    chk("rst_valid", 16'(bus.OUT_VALID), 16'd0);
    chk("rst_level", 16'(bus.FIFO_LEVEL), 16'd0);
    chk("rst_ovf", 16'(bus.OVERFLOW), 16'd0);
    chk("rst_col", 16'(bus.COLLIDE), 16'd0);
`ifdef DQ_CAPTURE_CMP_EN
    chk("rst_mm", 16'(bus.MISMATCH), 16'd0);
    chk("rst_mmcnt", bus.MISMATCH_CNT, 16'd0);
`endif
    RST_N = 1'b1;
    step(); step();

    // RD with L=5, A5 present only in the fifth cycle after it
    rd(5, 8'hA5);
    step();
    bus.RD = 1'b0; bus.RD_LAT = 5'd31;
    step(); step(); step();
    bus.DQ_OUT = 8'hFF;
    step();
    chk("l5_early_valid", 16'(bus.OUT_VALID), 16'd0);
    bus.DQ_OUT = 8'hA5;
    step();
    bus.DQ_OUT = 8'h00;
    chk("l5_valid", 16'(bus.OUT_VALID), 16'd1);
    chk("l5_data", 16'(bus.OUT_DATA), 16'h00A5);
    chk("l5_level", 16'(bus.FIFO_LEVEL), 16'd1);
    bus.OUT_READY = 1'b1;
    step();
    bus.OUT_READY = 1'b0;
    chk("l5_pop_level", 16'(bus.FIFO_LEVEL), 16'd0);
    chk("l5_pop_valid", 16'(bus.OUT_VALID), 16'd0);

    // L=0 samples the same cycle as RD
    rd(0, 8'h3C);
    bus.DQ_OUT = 8'h3C;
    step();
    bus.RD = 1'b0; bus.DQ_OUT = 8'h00;
    chk("l0_valid", 16'(bus.OUT_VALID), 16'd1);
    chk("l0_data", 16'(bus.OUT_DATA), 16'h003C);
    bus.OUT_READY = 1'b1;
    step();
    bus.OUT_READY = 1'b0;
    chk("l0_pop_level", 16'(bus.FIFO_LEVEL), 16'd0);
    chk("pre_col", 16'(bus.COLLIDE), 16'd0);

    // Cycle 0 L=4 and cycle 2 L=2 both target cycle 4; older expected byte kept
    rd(4, 8'h5A);
    step();
    bus.RD = 1'b0;
    step();
    rd(2, 8'h00);
    step();
    bus.RD = 1'b0;
    step();
    bus.DQ_OUT = 8'h5A;
    step();
    bus.DQ_OUT = 8'h00;
    chk("col_flag", 16'(bus.COLLIDE), 16'd1);
    chk("col_level", 16'(bus.FIFO_LEVEL), 16'd1);
    chk("col_data", 16'(bus.OUT_DATA), 16'h005A);
    step();
    chk("col_single", 16'(bus.FIFO_LEVEL), 16'd1);
`ifdef DQ_CAPTURE_CMP_EN
    chk("col_older_exp", 16'(bus.MISMATCH), 16'd0);
`endif
    bus.OUT_READY = 1'b1;
    step();
    bus.OUT_READY = 1'b0;
    chk("col_drain", 16'(bus.FIFO_LEVEL), 16'd0);

    // Nine L=0 captures into an 8-entry FIFO with no consumer
    for (int i = 0; i < 9; i++) begin
      rd(0, 8'(8'h10 + i));
      bus.DQ_OUT = 8'(8'h10 + i);
      step();
      if (i == 7) chk("fill_no_ovf", 16'(bus.OVERFLOW), 16'd0);
    end
    bus.RD = 1'b0; bus.DQ_OUT = 8'h00;
    chk("full_level", 16'(bus.FIFO_LEVEL), 16'd8);
    chk("full_ovf", 16'(bus.OVERFLOW), 16'd1);
    chk("full_head", 16'(bus.OUT_DATA), 16'h0010);
    rd(0, 8'h99);
    bus.DQ_OUT = 8'h99;
    bus.OUT_READY = 1'b1;
    step();
    bus.RD = 1'b0; bus.DQ_OUT = 8'h00;
    chk("pushpop_level", 16'(bus.FIFO_LEVEL), 16'd8);
    chk("pushpop_ovf", 16'(bus.OVERFLOW), 16'd1);
    for (int i = 0; i < 8; i++) begin
      logic [7:0] want;
      want = (i == 7) ? 8'h99 : 8'(8'h11 + i);
      chk($sformatf("drain_%0d", i), 16'(bus.OUT_DATA), 16'(want));
      step();
    end
    bus.OUT_READY = 1'b0;
    chk("drain_empty", 16'(bus.OUT_VALID), 16'd0);

    // Reset with three reads still pending
    rd(3, 8'h00); step();
    rd(5, 8'h00); step();
    rd(7, 8'h00); step();
    bus.RD = 1'b0;
    RST_N = 1'b0;
    step();
    RST_N = 1'b1;
    bus.DQ_OUT = 8'hEE;
    for (int i = 0; i < 10; i++) step();
    bus.DQ_OUT = 8'h00;
    chk("rstmid_valid", 16'(bus.OUT_VALID), 16'd0);
    chk("rstmid_level", 16'(bus.FIFO_LEVEL), 16'd0);
    chk("rstmid_ovf", 16'(bus.OVERFLOW), 16'd0);
    chk("rstmid_col", 16'(bus.COLLIDE), 16'd0);

`ifdef DQ_CAPTURE_CMP_EN
    rd(2, 8'h11); step();
    bus.RD = 1'b0;
    step();
    bus.DQ_OUT = 8'h10;
    step();
    bus.DQ_OUT = 8'h00;
    chk("mm_flag", 16'(bus.MISMATCH), 16'd1);
    chk("mm_cnt1", bus.MISMATCH_CNT, 16'd1);
    chk("mm_data", 16'(bus.OUT_DATA), 16'h0010);
    bus.OUT_READY = 1'b1;
    rd(1, 8'h22); step();
    bus.RD = 1'b0;
    bus.DQ_OUT = 8'h22;
    step();
    bus.DQ_OUT = 8'h00;
    step();
    bus.OUT_READY = 1'b0;
    chk("mm_cnt_hold", bus.MISMATCH_CNT, 16'd1);
    chk("mm_flag_hold", 16'(bus.MISMATCH), 16'd1);
`endif

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end
endmodule
